// File: rtl/hex_display_sequencer.sv
// Round-robin arbiter that takes a packed hex value from one of two requesters
// and writes each digit's active-low 7-segment code to consecutive HEX PIO registers.
module hex_display_sequencer #(
    parameter int NUM_DIGITS   = 4,
    parameter int ADDR_W       = 8,
    parameter int BASE_ADDR    = 0,
    parameter int DIGIT_STRIDE = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req0_valid,
    input  logic [4*NUM_DIGITS-1:0] req0_value,
    input  logic                    req0_blank_lz,
    output logic                    req0_ready,
    input  logic                    req1_valid,
    input  logic [4*NUM_DIGITS-1:0] req1_value,
    input  logic                    req1_blank_lz,
    output logic                    req1_ready,
    output logic [ADDR_W-1:0]       avm_address,
    output logic                    avm_write,
    output logic [31:0]             avm_writedata,
    input  logic                    avm_waitrequest,
    output logic                    busy,
    output logic                    last_grant
);

    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic {IDLE, WRITE} state_t;

    function automatic logic [7:0] hex_code(input logic [3:0] nib);
        logic [7:0] c;
        case (nib)
            4'h0: c = 8'hC0;
            4'h1: c = 8'hF9;
            4'h2: c = 8'hA4;
            4'h3: c = 8'hB0;
            4'h4: c = 8'h99;
            4'h5: c = 8'h92;
            4'h6: c = 8'h82;
            4'h7: c = 8'hF8;
            4'h8: c = 8'h80;
            4'h9: c = 8'h90;
            4'hA: c = 8'h88;
            4'hB: c = 8'h83;
            4'hC: c = 8'hC6;
            4'hD: c = 8'hA1;
            4'hE: c = 8'h86;
            default: c = 8'h8E;
        endcase
        return c;
    endfunction

    // A digit is a leading zero when it and every nibble above it are zero;
    // digit 0 always shows so an all-zero value still reads "0".
    function automatic logic [7:0] digit_code(input logic [VAL_W-1:0] val,
                                              input logic blank, input int i);
        logic [VAL_W-1:0] upper;
        upper = val >> (4 * i);
        if (blank && i != 0 && upper == '0)
            return 8'hFF;
        return hex_code(upper[3:0]);
    endfunction

    function automatic logic [ADDR_W-1:0] digit_addr(input int i);
        return ADDR_W'(BASE_ADDR + i * DIGIT_STRIDE);
    endfunction

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [VAL_W-1:0]    value_q, value_d;
    logic                blank_q, blank_d;
    logic                last_grant_q, last_grant_d;
    logic                ready0_q, ready0_d;
    logic                ready1_q, ready1_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          data_q, data_d;

    logic                any_valid, pick, offer, xfer_done, last_digit;
    logic [VAL_W-1:0]    latch_value;
    logic                latch_blank;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        value_d      = value_q;
        blank_d      = blank_q;
        last_grant_d = last_grant_q;
        write_d      = write_q;
        addr_d       = addr_q;
        data_d       = data_q;
        ready0_d     = 1'b0;
        ready1_d     = 1'b0;
        offer        = 1'b0;

        any_valid   = req0_valid | req1_valid;
        pick        = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        latch_value = last_grant_q ? req1_value : req0_value;
        latch_blank = last_grant_q ? req1_blank_lz : req0_blank_lz;
        xfer_done   = write_q & ~avm_waitrequest;
        last_digit  = (idx_q == IDX_W'(NUM_DIGITS - 1));

        case (state_q)
            IDLE: begin
                // A ready pulse is the acceptance cycle: capture the granted value now.
                if (ready0_q || ready1_q) begin
                    state_d = WRITE;
                    value_d = latch_value;
                    blank_d = latch_blank;
                    idx_d   = '0;
                    write_d = 1'b1;
                    addr_d  = digit_addr(0);
                    data_d  = digit_code(latch_value, latch_blank, 0);
                end else begin
                    offer = any_valid;
                end
            end
            WRITE: begin
                if (xfer_done) begin
                    if (last_digit) begin
                        state_d = IDLE;
                        write_d = 1'b0;
                        offer   = any_valid;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        addr_d = digit_addr(int'(idx_q) + 1);
                        data_d = digit_code(value_q, blank_q, int'(idx_q) + 1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Offering while finishing the last digit lets the ready pulse land in
        // the first IDLE cycle.
        if (offer) begin
            last_grant_d = pick;
            ready0_d     = ~pick;
            ready1_d     = pick;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            value_q      <= '0;
            blank_q      <= 1'b0;
            last_grant_q <= 1'b1;
            ready0_q     <= 1'b0;
            ready1_q     <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            value_q      <= value_d;
            blank_q      <= blank_d;
            last_grant_q <= last_grant_d;
            ready0_q     <= ready0_d;
            ready1_q     <= ready1_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
        end
    end

    assign req0_ready    = ready0_q;
    assign req1_ready    = ready1_q;
    assign avm_address   = addr_q;
    assign avm_write     = write_q;
    assign avm_writedata = {24'b0, data_q};
    assign busy          = (state_q == WRITE);
    assign last_grant    = last_grant_q;

endmodule

// File: tb/tb_hex_display_sequencer.sv
// Randomized bench for hex_display_sequencer: completed writes are collected at
// the falling edge and compared against a table-driven model of the display rules.
module tb_hex_display_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req0_blank_lz, req0_ready;
    logic [15:0] req0_value;
    logic        req1_valid, req1_blank_lz, req1_ready;
    logic [15:0] req1_value;
    logic [7:0]  avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic        busy, last_grant;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } xfer_t;

    xfer_t obs[$];
    xfer_t exp_q[$];
    int    total = 0, bad = 0, cyc = 0;
    int    write_cycles, stall_cycles, busy_cycles, ready0_cnt, ready1_cnt;
    int    first_write_cyc, last_write_cyc, last_ready_cyc;
    bit    prev_stall = 0, prev_write = 0;
    logic [7:0]  prev_addr;
    logic [31:0] prev_data;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    hex_display_sequencer #(.NUM_DIGITS(4), .ADDR_W(8), .BASE_ADDR(0), .DIGIT_STRIDE(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_value(req0_value), .req0_blank_lz(req0_blank_lz),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_value(req1_value), .req1_blank_lz(req1_blank_lz),
        .req1_ready(req1_ready),
        .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest), .busy(busy), .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference: digit i shows seg_tab[nibble], or blank when leading zeros are
    // suppressed and nothing nonzero sits at or above it (digit 0 excepted).
    function automatic logic [31:0] model_data(logic [15:0] v, bit b, int i);
        int rest;
        rest = int'(v) / (1 << (4 * i));
        if (b && i > 0 && rest == 0) return 32'h0000_00FF;
        return {24'b0, seg_tab[rest % 16]};
    endfunction

    function automatic void model_push(logic [15:0] v, bit b);
        for (int i = 0; i < 4; i++) exp_q.push_back({8'(4 * i), model_data(v, b, i)});
    endfunction

    // Falling-edge monitor: record completed transfers and check stall hold.
    initial forever begin
        @(negedge clk);
        if (avm_write && !avm_waitrequest) obs.push_back({avm_address, avm_writedata});
        if (avm_write) begin
            write_cycles++;
            if (!prev_write) first_write_cyc = cyc;
            last_write_cyc = cyc;
        end
        if (avm_write && avm_waitrequest) stall_cycles++;
        if (busy) busy_cycles++;
        if (req0_ready) ready0_cnt++;
        if (req1_ready) ready1_cnt++;
        if (req0_ready || req1_ready) begin
            last_ready_cyc = cyc;
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL ready_outside_idle cyc=%0d busy=%b want 0", cyc, busy);
            end
        end
        if (prev_stall && reset_n) begin
            total++;
            if ({avm_write, avm_address, avm_writedata} !== {1'b1, prev_addr, prev_data}) begin
                bad++;
                $display("FAIL stall_hold got w=%b a=%h d=%h want w=1 a=%h d=%h",
                         avm_write, avm_address, avm_writedata, prev_addr, prev_data);
            end
        end
        prev_stall = reset_n && avm_write && avm_waitrequest;
        prev_write = avm_write;
        prev_addr  = avm_address;
        prev_data  = avm_writedata;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        obs.delete();
        exp_q.delete();
        write_cycles = 0; stall_cycles = 0; busy_cycles = 0;
        ready0_cnt = 0; ready1_cnt = 0;
    endtask

    task automatic drive_req(input bit p, input bit v, input logic [15:0] val, input bit b);
        if (p) begin req1_valid = v; req1_value = val; req1_blank_lz = b; end
        else   begin req0_valid = v; req0_value = val; req0_blank_lz = b; end
    endtask

    // Present one request, hold it through acceptance, then let it drain with
    // random waitrequest stalls.
    task automatic issue(input bit p, input logic [15:0] v, input bit b, input int stall_pct);
        int t;
        drive_req(p, 1'b1, v, b);
        for (t = 0; t < 50; t++) begin
            cycle();
            if (p ? req1_ready : req0_ready) break;
        end
        if (t == 50) begin
            total++; bad++;
            $display("FAIL accept_timeout port=%0d got no ready want ready", p);
        end
        cycle();
        drive_req(p, 1'b0, 16'($urandom), b);
        for (t = 0; t < 200 && busy; t++) begin
            avm_waitrequest = ($urandom_range(99) < stall_pct);
            cycle();
        end
        avm_waitrequest = 1'b0;
        if (busy) begin
            total++; bad++;
            $display("FAIL drain_timeout port=%0d busy=%b want 0", p, busy);
        end
        model_push(v, b);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cycle(); cycle();
        total += 7;
        if (avm_write !== 1'b0)      begin bad++; $display("FAIL rst_write got=%b want=0", avm_write); end
        if (avm_address !== 8'h00)   begin bad++; $display("FAIL rst_addr got=%h want=00", avm_address); end
        if (avm_writedata !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=0", avm_writedata); end
        if (busy !== 1'b0)           begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        if (req0_ready !== 1'b0)     begin bad++; $display("FAIL rst_ready0 got=%b want=0", req0_ready); end
        if (req1_ready !== 1'b0)     begin bad++; $display("FAIL rst_ready1 got=%b want=0", req1_ready); end
        if (last_grant !== 1'b1)     begin bad++; $display("FAIL rst_last_grant got=%b want=1", last_grant); end
        reset_n = 1'b1;
        cycle();
    endtask

    task automatic test_basic();
        clear_stats();
        issue(1'b0, 16'h1234, 1'b0, 0);
        total += 5;
        if (obs.size() != 4) begin bad++; $display("FAIL basic_count got=%0d want=4", obs.size()); end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL basic_xfer%0d got=%h want=%h", i, obs[i], exp_q[i]); end
        end
        if (write_cycles != 4) begin bad++; $display("FAIL basic_write_cycles got=%0d want=4", write_cycles); end
        if (busy_cycles != 4)  begin bad++; $display("FAIL basic_busy_cycles got=%0d want=4", busy_cycles); end
        if (ready0_cnt != 1)   begin bad++; $display("FAIL basic_ready_pulse got=%0d want=1", ready0_cnt); end
        if (first_write_cyc != last_ready_cyc + 1) begin
            bad++; $display("FAIL basic_latency got=%0d want=%0d", first_write_cyc, last_ready_cyc + 1);
        end
    endtask

    task automatic test_blank();
        clear_stats();
        issue(1'b1, 16'h0070, 1'b1, 0);
        issue(1'b1, 16'h0000, 1'b1, 0);
        total++;
        if (obs.size() != 8) begin bad++; $display("FAIL blank_count got=%0d want=8", obs.size()); end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL blank_xfer%0d got=%h want=%h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_stall();
        int t, a4 = 0, stalls = 0;
        clear_stats();
        drive_req(1'b0, 1'b1, 16'h89AB, 1'b0);
        for (t = 0; t < 50 && !req0_ready; t++) cycle();
        cycle();
        drive_req(1'b0, 1'b0, 16'h0000, 1'b0);
        for (t = 0; t < 50 && busy; t++) begin
            if (avm_write && avm_address == 8'd4) a4++;
            if (avm_write && avm_address == 8'd4 && stalls < 3) begin
                avm_waitrequest = 1'b1; stalls++;
            end else avm_waitrequest = 1'b0;
            cycle();
        end
        avm_waitrequest = 1'b0;
        model_push(16'h89AB, 1'b0);
        total += 4;
        if (a4 != 4)           begin bad++; $display("FAIL stall_addr4_cycles got=%0d want=4", a4); end
        if (write_cycles != 7) begin bad++; $display("FAIL stall_write_cycles got=%0d want=7", write_cycles); end
        if (stall_cycles != 3) begin bad++; $display("FAIL stall_cycles got=%0d want=3", stall_cycles); end
        if (obs.size() != 4)   begin bad++; $display("FAIL stall_count got=%0d want=4", obs.size()); end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL stall_xfer%0d got=%h want=%h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            bit          p, b;
            logic [15:0] v;
            clear_stats();
            p = 1'($urandom_range(1));
            b = 1'($urandom_range(1));
            v = 16'($urandom) >> $urandom_range(15);
            issue(p, v, b, 30);
            total += 2;
            if (obs.size() != 4) begin bad++; $display("FAIL rand%0d_count got=%0d want=4", n, obs.size()); end
            if (write_cycles != 4 + stall_cycles) begin
                bad++; $display("FAIL rand%0d_cycles got=%0d want=%0d", n, write_cycles, 4 + stall_cycles);
            end
            for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
                total++;
                if (obs[i] !== exp_q[i]) begin
                    bad++; $display("FAIL rand%0d_xfer%0d v=%h b=%0d got=%h want=%h", n, i, v, b, obs[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_arbitration();
        int t, n = 0;
        bit g [4];
        bit lg [4];
        clear_stats();
        reset_n = 1'b0;
        cycle(); cycle();
        drive_req(1'b0, 1'b1, 16'h0C5E, 1'b0);
        drive_req(1'b1, 1'b1, 16'h00A7, 1'b1);
        reset_n = 1'b1;
        for (t = 0; t < 100 && n < 4; t++) begin
            cycle();
            if (req0_ready || req1_ready) begin
                g[n] = req1_ready; lg[n] = last_grant; n++;
            end
        end
        cycle();
        drive_req(1'b0, 1'b0, 16'h0, 1'b0);
        drive_req(1'b1, 1'b0, 16'h0, 1'b0);
        for (t = 0; t < 50 && busy; t++) cycle();
        total++;
        if (n != 4) begin bad++; $display("FAIL arb_grants got=%0d want=4", n); end
        for (int i = 0; i < n; i++) begin
            total += 2;
            if (g[i] !== 1'(i % 2))  begin bad++; $display("FAIL arb_order%0d got=%0d want=%0d", i, g[i], i % 2); end
            if (lg[i] !== 1'(i % 2)) begin bad++; $display("FAIL arb_last_grant%0d got=%0d want=%0d", i, lg[i], i % 2); end
            if (i % 2 == 0) model_push(16'h0C5E, 1'b0);
            else            model_push(16'h00A7, 1'b1);
        end
        total++;
        if (obs.size() != exp_q.size()) begin bad++; $display("FAIL arb_count got=%0d want=%0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL arb_xfer%0d got=%h want=%h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_wait_while_busy();
        int t, r = -1, m;
        clear_stats();
        drive_req(1'b1, 1'b1, 16'h5A3C, 1'b0);
        for (t = 0; t < 50 && !req1_ready; t++) cycle();
        cycle();
        drive_req(1'b1, 1'b0, 16'h0, 1'b0);
        drive_req(1'b0, 1'b1, 16'h0E01, 1'b1);
        for (t = 0; t < 50; t++) begin
            cycle();
            if (req0_ready) begin r = cyc; break; end
        end
        m = last_write_cyc;
        cycle();
        drive_req(1'b0, 1'b0, 16'h0, 1'b0);
        total += 3;
        if (r != m + 1) begin bad++; $display("FAIL busy_accept_cycle got=%0d want=%0d", r, m + 1); end
        if (avm_write !== 1'b1 || avm_address !== 8'h00) begin
            bad++; $display("FAIL busy_next_write got w=%b a=%h want w=1 a=00", avm_write, avm_address);
        end
        for (t = 0; t < 50 && busy; t++) cycle();
        model_push(16'h5A3C, 1'b0);
        model_push(16'h0E01, 1'b1);
        if (obs.size() != 8) begin bad++; $display("FAIL busy_count got=%0d want=8", obs.size()); end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL busy_xfer%0d got=%h want=%h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int t;
        clear_stats();
        drive_req(1'b0, 1'b1, 16'hFFFF, 1'b0);
        for (t = 0; t < 50 && !req0_ready; t++) cycle();
        cycle();
        drive_req(1'b0, 1'b0, 16'h0, 1'b0);
        for (t = 0; t < 20 && !(avm_write && avm_address == 8'd8); t++) cycle();
        reset_n = 1'b0;
        #1;
        total += 3;
        if (avm_write !== 1'b0)    begin bad++; $display("FAIL midrst_write got=%b want=0", avm_write); end
        if (busy !== 1'b0)         begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        if (avm_address !== 8'h00) begin bad++; $display("FAIL midrst_addr got=%h want=00", avm_address); end
        write_cycles = 0;
        cycle(); cycle();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        model_push(16'hFFFF, 1'b0);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        total += 3;
        if (write_cycles != 0) begin bad++; $display("FAIL midrst_replay got=%0d want=0", write_cycles); end
        if (busy !== 1'b0)     begin bad++; $display("FAIL midrst_idle got=%b want=0", busy); end
        if (obs.size() != 2)   begin bad++; $display("FAIL midrst_count got=%0d want=2", obs.size()); end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL midrst_xfer%0d got=%h want=%h", i, obs[i], exp_q[i]); end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req0_valid = 1'b0; req0_value = '0; req0_blank_lz = 1'b0;
        req1_valid = 1'b0; req1_value = '0; req1_blank_lz = 1'b0;
        avm_waitrequest = 1'b0;
        clear_stats();
        test_reset();
        test_basic();
        test_blank();
        test_stall();
        test_random();
        test_arbitration();
        test_wait_while_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
